// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC + 1-cycle imem reads into a FIFO_DEPTH buffer; request->out_valid 2 cycles, 1 instr/cycle, stalls on out_ready=0.
// Redirect flushes and re-steers via an epoch tag; FETCH_PERF_CNT_EN adds perf_fetched/perf_bubble counters.
module instr_fetch_unit #(
  parameter int          ADDR_WIDTH = 15,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  input  logic                  imem_wr_busy,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [31:0]           out_pc,
  output logic [6:0]            out_opcode,
  output logic [2:0]            out_funct3,
  output logic [6:0]            out_funct7
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_bubble
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] LP_DEPTH = FIFO_DEPTH[CW:0];

  typedef enum logic {ST_BOOT, ST_RUN} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_fetch_pc;
  logic            r_inflight;
  logic [31:0]     r_tag_pc;
  logic            r_tag_epoch;
  logic            r_epoch;
  logic [31:0]     r_mem_instr [FIFO_DEPTH];
  logic [31:0]     r_mem_pc    [FIFO_DEPTH];
  logic [PW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic            w_issue, w_push, w_pop;
  logic [CW:0]     w_occ;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_occ = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_BOOT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN:  w_issue = !imem_wr_busy && !redirect && (w_occ < LP_DEPTH);
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // Stale responses (older epoch) and anything landing alongside a redirect are dropped.
  assign w_push = r_inflight && (r_tag_epoch == r_epoch) && !redirect;
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc  <= RESET_PC;
      r_inflight  <= 1'b0;
      r_tag_pc    <= '0;
      r_tag_epoch <= 1'b0;
      r_epoch     <= 1'b0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_instr[i] <= '0;
        r_mem_pc[i]    <= '0;
      end
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag_pc    <= r_fetch_pc;
        r_tag_epoch <= r_epoch;
      end
      if (redirect) begin
        r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        r_epoch    <= ~r_epoch;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push) begin
          r_mem_instr[r_wr_ptr] <= imem_rdata;
          r_mem_pc[r_wr_ptr]    <= r_tag_pc;
          r_wr_ptr              <= f_inc(r_wr_ptr);
        end
        if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign imem_en    = w_issue;
  assign imem_addr  = w_issue ? r_fetch_pc[ADDR_WIDTH+1:2] : '0;
  assign out_valid  = (r_count != '0);
  assign out_instr  = out_valid ? r_mem_instr[r_rd_ptr] : '0;
  assign out_pc     = out_valid ? r_mem_pc[r_rd_ptr] : '0;
  assign out_opcode = out_instr[6:0];
  assign out_funct3 = out_instr[14:12];
  assign out_funct7 = out_instr[31:25];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched, r_perf_bubble;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_bubble  <= '0;
    end else begin
      if (w_pop) r_perf_fetched <= r_perf_fetched + 32'd1;
      if ((r_state == ST_RUN) && out_ready && !out_valid) r_perf_bubble <= r_perf_bubble + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_bubble  = r_perf_bubble;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit: BRAM model, in-order PC-stream scoreboard.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_en;
  logic [14:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_wr_busy = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_pc;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubble;
`endif

  instr_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_wr_busy(imem_wr_busy), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_bubble(perf_bubble)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] imem [1024];
  always @(posedge clk) if (imem_en) imem_rdata <= imem[imem_addr[9:0]];

  int checks = 0;
  int errors = 0;

  // Reference model: the accepted stream is exp_pc, exp_pc+4, ... restarting at each redirect target.
  logic [31:0] exp_pc;
  logic [31:0] exp_w;
  logic [31:0] m_fetched, m_bubble;
  int          cyc_k;
  logic        prev_redir, prev_hold;
  logic [31:0] prev_pc, prev_instr;
  logic        last_vld, last_en, popped;
  logic [14:0] last_addr;
  logic [31:0] last_pop_pc;
  logic [6:0]  last_opc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_zero();
    chk("rst_en", {31'b0, imem_en}, 0);
    chk("rst_addr", {17'b0, imem_addr}, 0);
    chk("rst_vld", {31'b0, out_valid}, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc", out_pc, 0);
  endtask

  task automatic model_reset();
    exp_pc = 32'h0; m_fetched = 0; m_bubble = 0; cyc_k = 0;
    prev_redir = 0; prev_hold = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1 check_zero();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic cyc(input logic rdy, input logic busy, input logic redir, input logic [31:0] rpc);
    out_ready = rdy; imem_wr_busy = busy; redirect = redir; redirect_pc = rpc;
    @(negedge clk);
    last_vld = out_valid; last_en = imem_en; last_addr = imem_addr; last_opc = out_opcode;
    popped = 0;
    if (prev_redir) chk("redir_vld", {31'b0, out_valid}, 0);
    if (prev_hold) begin
      chk("hold_vld", {31'b0, out_valid}, 1);
      chk("hold_pc", out_pc, prev_pc);
      chk("hold_instr", out_instr, prev_instr);
    end
    if (busy || redir || cyc_k == 0) chk("blocked_en", {31'b0, imem_en}, 0);
    if (out_valid && rdy) begin
      exp_w = imem[exp_pc[11:2]];
      chk("pop_pc", out_pc, exp_pc);
      chk("pop_instr", out_instr, exp_w);
      chk("pop_fields", {15'b0, out_funct7, out_funct3, out_opcode}, {15'b0, exp_w[31:25], exp_w[14:12], exp_w[6:0]});
      popped = 1; last_pop_pc = out_pc;
      exp_pc = exp_pc + 32'd4;
      m_fetched = m_fetched + 1;
    end
    if (cyc_k >= 1 && rdy && !out_valid) m_bubble = m_bubble + 1;
    prev_hold  = out_valid && !rdy && !redir;
    prev_pc    = out_pc;
    prev_instr = out_instr;
    prev_redir = redir;
    if (redir) exp_pc = rpc & 32'hFFFF_FFFC;
    cyc_k++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int en_cnt;
    logic got;
    for (int i = 0; i < 1024; i++) imem[i] = $urandom;
    imem[0] = 32'h00000013; imem[1] = 32'h00100093;
    imem[2] = 32'h00200113; imem[3] = 32'h00300193;
    model_reset();

    // Boot timing and first stream
    @(posedge clk);
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc(1, 0, 0, 0);
      chk("boot_vld", {31'b0, last_vld}, (k >= 3) ? 1 : 0);
      if (k == 1) chk("first_en", {31'b0, last_en}, 1);
      if (k == 3) chk("first_opcode", {25'b0, last_opc}, 32'h13);
    end

    // Stall from reset: exactly three requests fill the buffer
    do_reset();
    en_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 0, 0);
      if (last_en) en_cnt++;
    end
    chk("stall_reqs", en_cnt, 3);
    chk("stall_en_off", {31'b0, last_en}, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0, 0);
      chk("drain_nogap", {31'b0, popped}, 1);
    end
    repeat (3) cyc(1, 0, 0, 0);

    // Redirect with two buffered entries and one read in flight
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h0000_0102);
    chk("redir_had_vld", {31'b0, last_vld}, 1);
    cyc(1, 0, 0, 0);
    chk("redir_req_en", {31'b0, last_en}, 1);
    chk("redir_req_addr", {17'b0, last_addr}, 32'h40);
    cyc(1, 0, 0, 0);
    chk("redir_gap", {31'b0, last_vld}, 0);
    cyc(1, 0, 0, 0);
    chk("redir_first_vld", {31'b0, last_vld}, 1);
    chk("redir_first_pc", last_pop_pc, 32'h100);
    repeat (3) cyc(1, 0, 0, 0);

    // Back-to-back redirects: the later target wins
    cyc(1, 0, 1, 32'h40);
    cyc(1, 0, 1, 32'h80);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      cyc(1, 0, 0, 0);
      got = popped;
    end
    chk("b2b_got", {31'b0, got}, 1);
    chk("b2b_first_pc", last_pop_pc, 32'h80);

    // imem write-port busy mid-stream
    repeat (3) cyc(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 1, 0, 0);
    repeat (6) cyc(1, 0, 0, 0);

`ifdef FETCH_PERF_CNT_EN
    do_reset();
    for (int k = 0; k < 11; k++) cyc(1, 0, 0, 0);
    out_ready = 0;
    chk("perf_fetched", perf_fetched, 8);
    chk("perf_bubble", perf_bubble, 2);
    chk("perf_fetched_model", perf_fetched, m_fetched);
`endif

    // Asynchronous reset mid-stream: outputs clear before any clock edge
    repeat (2) cyc(1, 0, 0, 0);
    rst = 1'b1;
    #1 check_zero();
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_f", perf_fetched, 0);
    chk("rst_perf_b", perf_bubble, 0);
`endif
    do_reset();

    // Randomized traffic against the stream model
    for (int k = 0; k < 400; k++) begin
      logic rd, bz, rj;
      rd = ($urandom_range(0, 9) < 7);
      bz = ($urandom_range(0, 9) == 0);
      rj = ($urandom_range(0, 19) == 0);
      cyc(rd, bz, rj, $urandom_range(0, 4095));
    end
    repeat (6) cyc(1, 0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("rand_perf_f", perf_fetched, m_fetched);
    chk("rand_perf_b", perf_bubble, m_bubble);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
